decode_execute_pipe_n: RTL

Parametrised decode-to-execute pipeline register for the multi-issue core: LANES independent issue slots, each carrying a packed decode payload plus a valid bit from the decode stage to the execute stage. Compared with the fixed dual-lane register, it adds explicit per-lane valid, a younger-lane kill cascade, an optional lockstep enable mode, and per-lane saturating stall-cycle counters for performance monitoring. It sits between the decoder/register-file read and the execute-stage forwarding muxes, and is driven by the hazard unit.

---
 rtl/pipe_pkg.sv | 62 ++++++
 rtl/de_lane_reg.sv | 46 ++++
 rtl/decode_execute_pipe_n.sv | 58 +++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Decode-to-execute payload layout shared by decode, the D/E register and execute.
// Fields are packed MSB-first: control (19 bits) above data (175 bits).
package pipe_pkg;

  localparam int DE_CTRL_W    = 19;
  localparam int DE_DATA_W    = 175;
  localparam int DE_PAYLOAD_W = DE_CTRL_W + DE_DATA_W;

  localparam int REGWRITE_W   = 1;
  localparam int RESULTSRC_W  = 2;
  localparam int MEMWRITE_W   = 1;
  localparam int JUMP_W       = 1;
  localparam int BRANCH_W     = 1;
  localparam int ALUCTRL_W    = 4;
  localparam int ALUSRCA_W    = 2;
  localparam int ALUSRCB_W    = 1;
  localparam int ADDRCTRL_W   = 3;
  localparam int BRTYPE_W     = 3;
  localparam int XLEN         = 32;
  localparam int REG_W        = 5;

  localparam int PCPLUS4_OFF  = 0;
  localparam int IMMEXT_OFF   = 32;
  localparam int RD_OFF       = 64;
  localparam int RS2_OFF      = 69;
  localparam int RS1_OFF      = 74;
  localparam int PC_OFF       = 79;
  localparam int RD2_OFF      = 111;
  localparam int RD1_OFF      = 143;
  localparam int BRTYPE_OFF   = 175;
  localparam int ADDRCTRL_OFF = 178;
  localparam int ALUSRCB_OFF  = 181;
  localparam int ALUSRCA_OFF  = 182;
  localparam int ALUCTRL_OFF  = 184;
  localparam int BRANCH_OFF   = 188;
  localparam int JUMP_OFF     = 189;
  localparam int MEMWRITE_OFF = 190;
  localparam int RESULTSRC_OFF = 191;
  localparam int REGWRITE_OFF = 193;

  typedef struct packed {
    logic [REGWRITE_W-1:0]  reg_write;
    logic [RESULTSRC_W-1:0] result_src;
    logic [MEMWRITE_W-1:0]  mem_write;
    logic [JUMP_W-1:0]      jump;
    logic [BRANCH_W-1:0]    branch;
    logic [ALUCTRL_W-1:0]   alu_control;
    logic [ALUSRCA_W-1:0]   alu_src_a;
    logic [ALUSRCB_W-1:0]   alu_src_b;
    logic [ADDRCTRL_W-1:0]  addressing_control;
    logic [BRTYPE_W-1:0]    branch_type;
    logic [XLEN-1:0]        rd1;
    logic [XLEN-1:0]        rd2;
    logic [XLEN-1:0]        pc;
    logic [REG_W-1:0]       rs1;
    logic [REG_W-1:0]       rs2;
    logic [REG_W-1:0]       rd;
    logic [XLEN-1:0]        imm_ext;
    logic [XLEN-1:0]        pc_plus4;
  } de_payload_t;

endpackage

// File: rtl/de_lane_reg.sv
// One D/E lane: valid + payload register and a saturating stall counter.
// Ports: ee/kill from top, valid_d/payload_d in, valid_e/payload_e/stall_cnt out.
module de_lane_reg
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = DE_PAYLOAD_W,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ee,
  input  logic                 kill,
  input  logic                 cnt_clr,
  input  logic                 valid_d,
  input  logic [PAYLOAD_W-1:0] payload_d,
  output logic                 valid_e,
  output logic [PAYLOAD_W-1:0] payload_e,
  output logic [CNT_W-1:0]     stall_cnt
);

  // Kill zeroes the whole payload so no stale operands leak downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e   <= 1'b0;
      payload_e <= '0;
    end else if (kill) begin
      valid_e   <= 1'b0;
      payload_e <= '0;
    end else if (ee) begin
      valid_e   <= valid_d;
      payload_e <= payload_d;
    end
  end

  // Count only cycles where a live instruction is held in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (valid_e && !ee && !kill && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/decode_execute_pipe_n.sv
// LANES-wide decode-to-execute pipeline register with kill cascade and stall counters.
// Ports: en/flush/cnt_clr from hazard unit, valid_d/payload_d in, valid_e/payload_e/stall_cnt out.
module decode_execute_pipe_n
  import pipe_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int PAYLOAD_W    = DE_PAYLOAD_W,
  parameter int YOUNGER_KILL = 1,
  parameter int LOCKSTEP     = 0,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           en,
  input  logic [LANES-1:0]           flush,
  input  logic                       cnt_clr,
  input  logic [LANES-1:0]           valid_d,
  input  logic [LANES*PAYLOAD_W-1:0] payload_d,
  output logic [LANES-1:0]           valid_e,
  output logic [LANES*PAYLOAD_W-1:0] payload_e,
  output logic [LANES*CNT_W-1:0]     stall_cnt
);

  logic [LANES-1:0] ee;
  logic [LANES-1:0] kill;
  logic             older;

  // older accumulates flushes of all lanes ahead in program order.
  always_comb begin
    ee    = '0;
    kill  = '0;
    older = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      ee[i]   = (LOCKSTEP != 0) ? en[0] : en[i];
      kill[i] = flush[i] | ((YOUNGER_KILL != 0) & older);
      older   = older | flush[i];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    de_lane_reg #(
      .PAYLOAD_W (PAYLOAD_W),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .ee        (ee[g]),
      .kill      (kill[g]),
      .cnt_clr   (cnt_clr),
      .valid_d   (valid_d[g]),
      .payload_d (payload_d[g*PAYLOAD_W +: PAYLOAD_W]),
      .valid_e   (valid_e[g]),
      .payload_e (payload_e[g*PAYLOAD_W +: PAYLOAD_W]),
      .stall_cnt (stall_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule
